pe_output_arbiter: RTL and testbench

//  Shares the router's single PE-bound output channel between the cw and ccw input buffers.

---
 rtl/router_pkg.sv | 19 +
 rtl/pe_output_arbiter_if.sv | 34 +++
 rtl/rr_arb2.sv | 41 ++++
 rtl/pe_output_arbiter.sv | 93 +++++++++
 tb/tb_pe_output_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// router_pkg
//   Shared router definitions: default packet width, FSM state encoding for
//   output-register stages, and requester IDs for the cw/ccw input buffers.
//   No ports (package).
package router_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 64;

    // One-hot encoding of the one-entry output register occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // Requester IDs; also the bit index of each requester in req/gnt vectors
    localparam logic REQ_CW  = 1'b0;
    localparam logic REQ_CCW = 1'b1;

endpackage

// File: rtl/pe_output_arbiter_if.sv
// pe_output_arbiter_if
//   Bundles the cw/ccw buffer request/pop signals and the PE send/ready channel.
//   Signals:
//     cw_req, cw_data, cw_gnt    cw input buffer request, packet, pop strobe
//     ccw_req, ccw_data, ccw_gnt ccw input buffer request, packet, pop strobe
//     peso, pero, pedo           PE send (valid), PE ready, packet to PE
//   Modports:
//     master  the arbiter side (drives gnt strobes and the PE channel)
//     slave   the buffers/PE side
interface pe_output_arbiter_if
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  cw_req;
    logic [DATA_WIDTH-1:0] cw_data;
    logic                  cw_gnt;
    logic                  ccw_req;
    logic [DATA_WIDTH-1:0] ccw_data;
    logic                  ccw_gnt;
    logic                  peso;
    logic                  pero;
    logic [DATA_WIDTH-1:0] pedo;

    modport master (
        input  cw_req, cw_data, ccw_req, ccw_data, pero,
        output cw_gnt, ccw_gnt, peso, pedo
    );

    modport slave (
        output cw_req, cw_data, ccw_req, ccw_data, pero,
        input  cw_gnt, ccw_gnt, peso, pedo
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. Grant is combinational from i_req and the
//   registered pointer; the pointer moves to the losing side on every grant.
//   Ports:
//     clk, rst  clock, synchronous active-high reset (pointer -> cw)
//     i_req     [REQ_CW]=cw request, [REQ_CCW]=ccw request
//     i_en      grants are issued only while high
//     o_gnt     one-hot (or zero) grant, same indexing as i_req
module rr_arb2
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);
    logic r_ptr;
    logic w_win;

    always_comb begin
        o_gnt = '0;
        w_win = r_ptr;
        case (i_req)
            2'b01:   w_win = REQ_CW;
            2'b10:   w_win = REQ_CCW;
            default: w_win = r_ptr;   // both high: pointer side wins
        endcase
        if (i_en && (|i_req)) begin
            o_gnt[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= REQ_CW;
        end else if (|o_gnt) begin
            r_ptr <= ~w_win;
        end
    end
endmodule

// File: rtl/pe_output_arbiter.sv
// pe_output_arbiter
//   Shares the PE-bound output channel between the cw and ccw input buffers.
//   A round-robin winner is popped whenever the one-entry output register is
//   free; the register then offers the packet to the PE via peso/pero.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     bus (master)     buffer req/data/gnt and PE peso/pero/pedo
//     cw_cnt, ccw_cnt  saturating counts of packets popped from each side
module pe_output_arbiter
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
)(
    input  logic                 clk,
    input  logic                 rst,
    pe_output_arbiter_if.master  bus,
    output logic [CNT_WIDTH-1:0] cw_cnt,
    output logic [CNT_WIDTH-1:0] ccw_cnt
);
    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_pedo;
    logic [CNT_WIDTH-1:0]  r_cw_cnt;
    logic [CNT_WIDTH-1:0]  r_ccw_cnt;
    logic                  w_free;
    logic                  w_load;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;

    // Free when empty, or when the held packet leaves on this same edge
    assign w_free = (r_state == ST_EMPTY) || ((r_state == ST_FULL) && bus.pero);

    assign w_req[REQ_CW]  = bus.cw_req;
    assign w_req[REQ_CCW] = bus.ccw_req;

    // Gating with rst keeps pop strobes quiet while reset is held
    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .i_en  (w_free && !rst),
        .o_gnt (w_gnt)
    );

    assign w_load      = |w_gnt;
    assign bus.cw_gnt  = w_gnt[REQ_CW];
    assign bus.ccw_gnt = w_gnt[REQ_CCW];
    assign bus.pedo    = r_pedo;
    assign cw_cnt      = r_cw_cnt;
    assign ccw_cnt     = r_ccw_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        bus.peso = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) w_next = ST_FULL;
            end
            ST_FULL: begin
                bus.peso = 1'b1;
                if (bus.pero && !w_load) w_next = ST_EMPTY;
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pedo    <= '0;
            r_cw_cnt  <= '0;
            r_ccw_cnt <= '0;
        end else begin
            if (w_load) begin
                r_pedo <= w_gnt[REQ_CCW] ? bus.ccw_data : bus.cw_data;
            end
            if (w_gnt[REQ_CW] && (r_cw_cnt != '1)) begin
                r_cw_cnt <= r_cw_cnt + CNT_WIDTH'(1);
            end
            if (w_gnt[REQ_CCW] && (r_ccw_cnt != '1)) begin
                r_ccw_cnt <= r_ccw_cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pe_output_arbiter.sv
// tb_pe_output_arbiter
//   Drives two arbiter instances (16-bit and 2-bit counters) with identical
//   stimulus and compares them against a packet-level reference model.
module tb_pe_output_arbiter;
    import router_pkg::*;

    localparam int unsigned DW = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cw_cnt, ccw_cnt;
    logic [1:0]  cw_cnt_s, ccw_cnt_s;

    pe_output_arbiter_if #(.DATA_WIDTH(DW)) bus ();
    pe_output_arbiter_if #(.DATA_WIDTH(DW)) bus_s ();

    pe_output_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cw_cnt  (cw_cnt),
        .ccw_cnt (ccw_cnt)
    );

    pe_output_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_s),
        .cw_cnt  (cw_cnt_s),
        .ccw_cnt (ccw_cnt_s)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: is a packet waiting for the PE, what is it, whose turn
    // it is on a tie, and how many packets each side has handed over.
    bit          m_held = 0;
    logic [63:0] m_data = '0;
    bit          m_turn_ccw = 0;
    int unsigned m_ncw = 0;
    int unsigned m_nccw = 0;

    function automatic logic [63:0] sat(input int unsigned n, input int unsigned w);
        int unsigned lim;
        lim = (1 << w) - 1;
        return (n > lim) ? 64'(lim) : 64'(n);
    endfunction

    // Values observed during the most recent step (before its clock edge)
    logic        o_cwg, o_ccwg, o_peso;
    logic [63:0] o_pedo;
    logic [15:0] o_cwcnt, o_ccwcnt;
    logic [1:0]  o_cwcnt_s, o_ccwcnt_s;

    task automatic step(input bit r, input bit cwr, input bit ccwr,
                        input logic [63:0] dcw, input logic [63:0] dccw, input bit pr);
        bit e_cw, e_ccw;
        @(negedge clk);
        rst = r;
        bus.cw_req = cwr;   bus.ccw_req = ccwr;   bus.cw_data = dcw;   bus.ccw_data = dccw;   bus.pero = pr;
        bus_s.cw_req = cwr; bus_s.ccw_req = ccwr; bus_s.cw_data = dcw; bus_s.ccw_data = dccw; bus_s.pero = pr;
        #1;
        e_cw = 0; e_ccw = 0;
        if (!r && (!m_held || pr)) begin
            if (cwr && ccwr) begin
                if (m_turn_ccw) e_ccw = 1; else e_cw = 1;
            end else if (cwr) e_cw = 1;
            else if (ccwr) e_ccw = 1;
        end
        o_cwg = bus.cw_gnt; o_ccwg = bus.ccw_gnt; o_peso = bus.peso; o_pedo = bus.pedo;
        o_cwcnt = cw_cnt; o_ccwcnt = ccw_cnt; o_cwcnt_s = cw_cnt_s; o_ccwcnt_s = ccw_cnt_s;
        check("cw_gnt",    64'(o_cwg),  64'(e_cw));
        check("ccw_gnt",   64'(o_ccwg), 64'(e_ccw));
        check("peso",      64'(o_peso), 64'(m_held));
        check("pedo",      o_pedo,      m_data);
        check("cw_cnt",    64'(o_cwcnt),  sat(m_ncw, 16));
        check("ccw_cnt",   64'(o_ccwcnt), sat(m_nccw, 16));
        check("cw_cnt2",   64'(o_cwcnt_s),  sat(m_ncw, 2));
        check("ccw_cnt2",  64'(o_ccwcnt_s), sat(m_nccw, 2));
        check("gnt_sat",   64'({bus_s.cw_gnt, bus_s.ccw_gnt}), 64'({e_cw, e_ccw}));
        @(posedge clk);
        if (r) begin
            m_held = 0; m_data = '0; m_turn_ccw = 0; m_ncw = 0; m_nccw = 0;
        end else if (e_cw || e_ccw) begin
            m_held = 1;
            m_data = e_cw ? dcw : dccw;
            m_turn_ccw = e_cw;
            if (e_cw) m_ncw++; else m_nccw++;
        end else if (m_held && pr) begin
            m_held = 0;
        end
    endtask

    initial begin
        bus.cw_req = 0;   bus.ccw_req = 0;   bus.cw_data = '0;   bus.ccw_data = '0;   bus.pero = 0;
        bus_s.cw_req = 0; bus_s.ccw_req = 0; bus_s.cw_data = '0; bus_s.ccw_data = '0; bus_s.pero = 0;

        // Reset held with both requests: quiet; cw wins first after release
        step(1, 1, 1, 64'h1, 64'h2, 1);
        step(1, 1, 1, 64'h1, 64'h2, 1);
        check("t1_rst_gnt", 64'({o_cwg, o_ccwg}), 64'd0);
        step(0, 1, 1, 64'h1, 64'h2, 1);
        check("t1_first_cw", 64'(o_cwg), 64'd1);

        // Single cw packet
        step(1, 0, 0, '0, '0, 1);
        step(0, 1, 0, 64'hA5, '0, 1);
        check("t2_gnt", 64'(o_cwg), 64'd1);
        step(0, 0, 0, '0, '0, 1);
        check("t2_peso", 64'(o_peso), 64'd1);
        check("t2_pedo", o_pedo, 64'hA5);
        check("t2_cnt", 64'(o_cwcnt), 64'd1);
        step(0, 0, 0, '0, '0, 1);
        check("t2_empty", 64'(o_peso), 64'd0);

        // Backpressure holds the packet and blocks pops
        step(1, 0, 0, '0, '0, 0);
        step(0, 1, 0, 64'h11, '0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, '0, 64'h22, 0);
            check("t3_hold", o_pedo, 64'h11);
            check("t3_nognt", 64'(o_ccwg), 64'd0);
        end
        step(0, 0, 1, '0, 64'h22, 1);
        check("t3_pop", 64'(o_ccwg), 64'd1);
        step(0, 0, 0, '0, '0, 1);
        check("t3_pedo", o_pedo, 64'h22);

        // Fairness with both requesting and PE always ready
        step(1, 0, 0, '0, '0, 1);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 1, 64'(100 + k), 64'(200 + k), 1);
            check("t4_order", 64'({o_cwg, o_ccwg}), (k % 2 == 0) ? 64'b10 : 64'b01);
            if (k > 0) check("t4_peso", 64'(o_peso), 64'd1);
        end
        step(0, 0, 0, '0, '0, 1);
        check("t4_cw_cnt", 64'(o_cwcnt), 64'd3);
        check("t4_ccw_cnt", 64'(o_ccwcnt), 64'd3);

        // Saturation on the 2-bit counters
        step(1, 0, 0, '0, '0, 1);
        for (int k = 0; k < 6; k++) begin
            step(0, (k < 5), 0, 64'(k), '0, 1);
            check("t5_sat", 64'(o_cwcnt_s), 64'((k < 3) ? k : 3));
        end

        // Reset while full and stalled
        step(1, 0, 0, '0, '0, 0);
        step(0, 1, 0, 64'h33, '0, 0);
        step(1, 0, 0, '0, '0, 0);
        step(0, 1, 1, 64'h44, 64'h55, 0);
        check("t6_peso", 64'(o_peso), 64'd0);
        check("t6_cnt", 64'(o_cwcnt), 64'd0);
        check("t6_cw_wins", 64'(o_cwg), 64'd1);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
